// File: rtl/ddr_lane_pkg.sv
// rtl/ddr_lane_pkg.sv - shared types and sizing helpers for the DDR lane scheduler
package ddr_lane_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Default configuration; instances size themselves from their own parameters
  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_GAP   = 0;
  localparam int PAIRS     = DEF_WIDTH / 2;
  localparam int IDW       = $clog2(DEF_NREQ);
  localparam int CW        = $clog2(PAIRS + DEF_GAP + 1);

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_lane_scheduler_rr_arbiter.sv
// rtl/ddr_lane_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest valid at/after ptr wins last
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = IDW'((int'(ptr) + off) % NREQ);
      if (en && req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_lane_scheduler.sv
// rtl/ddr_lane_scheduler.sv - round-robin scheduler serialising frames onto one DDR lane
module ddr_lane_scheduler
  import ddr_lane_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int GAP   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     lane_rise,
  output logic                     lane_fall,
  output logic                     lane_en,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int NPAIRS = WIDTH / 2;
  localparam int ID_W   = $clog2(NREQ);
  localparam int C_W    = cnt_width(NPAIRS + GAP + 1);
  localparam logic [C_W-1:0]  LAST_PAIR = C_W'(NPAIRS - 1);
  localparam logic [C_W-1:0]  LAST_GAP  = C_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [ID_W-1:0] LAST_REQ  = ID_W'(NREQ - 1);

  state_t            state, state_nx;
  logic [WIDTH-1:0]  sr;
  logic [C_W-1:0]    cnt;
  logic [ID_W-1:0]   ptr;
  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;
  logic [WIDTH-1:0]  win_frame;

  // Arbitration is only live in IDLE; rst_n gates it so no ready leaks out while held in reset
  rr_arbiter #(.NREQ(NREQ), .IDW(ID_W)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  ((state == S_IDLE) && rst_n),
    .gnt (gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Select the winning requester's frame with constant slices
  always_comb begin
    win_frame = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) win_frame = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state decode and lane outputs, all derived from registered state
  always_comb begin
    state_nx  = state;
    req_ready = gnt;
    lane_en   = 1'b0;
    lane_rise = 1'b0;
    lane_fall = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (win_any) state_nx = S_SEND;
      S_SEND: begin
        lane_en   = 1'b1;
        lane_rise = sr[WIDTH-1];
        lane_fall = sr[WIDTH-2];
        if (cnt == LAST_PAIR) state_nx = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP:  if (cnt == LAST_GAP) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, shift register, pair/gap counter, RR pointer and grant register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sr       <= '0;
      cnt      <= '0;
      ptr      <= '0;
      grant_id <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (win_any) begin
          sr       <= win_frame;
          grant_id <= win_idx;
          ptr      <= (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
          cnt      <= '0;
        end
        S_SEND: begin
          sr  <= sr << 2;
          cnt <= (cnt == LAST_PAIR) ? '0 : cnt + 1'b1;
        end
        S_GAP:  cnt <= (cnt == LAST_GAP) ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

endmodule
